axi_rdata_fifo_drain: RTL and testbench

//  Read-side consumer of the SDRAM read-data async FIFO in the AXI2SDRAM wrapper, living in the AXI clock domain.

---
 rtl/axi_rdata_fifo_drain.sv | 108 ++++++++++
 tb/tb_axi_rdata_fifo_drain.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rdata_fifo_drain.sv
// AXI-domain drain of the SDRAM read-data FIFO: pops one burst's worth of words
// and replays them on the AXI4 R channel through a 2-entry skid buffer.
module axi_rdata_fifo_drain #(
    parameter int DATA_SIZE = 32,
    parameter int ID_W      = 4,
    parameter int LEN_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ID_W-1:0]      cmd_id,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [DATA_SIZE-1:0] fifo_data,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [DATA_SIZE-1:0] rdata,
    output logic [ID_W-1:0]      rid,
    output logic [1:0]           rresp,
    output logic                 rlast,
    output logic                 busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [LEN_W:0] CNT_ONE = (LEN_W + 1)'(1);

    state_t               state, state_nxt;
    logic [ID_W-1:0]      id_q;
    logic [LEN_W:0]       pop_left;
    logic [LEN_W:0]       send_left;
    logic                 inflight;
    logic [DATA_SIZE-1:0] buf_mem [2];
    logic                 head;
    logic [1:0]           occ;
    logic [1:0]           occ_after_send;
    logic                 send;
    logic                 wr_idx;
    logic                 cmd_take;

    assign busy      = (state == BURST);
    assign cmd_ready = (state == IDLE);
    assign cmd_take  = cmd_ready & cmd_valid;

    assign rvalid = (occ != 2'd0);
    assign rdata  = buf_mem[head];
    assign rid    = id_q;
    assign rresp  = 2'b00;
    assign rlast  = rvalid & (send_left == CNT_ONE);
    assign send   = rvalid & rready;

    // A head leaving this cycle frees its slot, so a pop may be issued against it;
    // this is what keeps one beat per cycle flowing with rready held high.
    assign occ_after_send = occ - {1'b0, send};
    assign fifo_rd_en     = busy & ~fifo_empty & (pop_left != '0)
                          & ((occ_after_send + {1'b0, inflight}) < 2'd2);

    // The tail slot sits occ entries past the head.
    assign wr_idx = head ^ occ[0];

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid)     state_nxt = BURST;
            BURST:   if (send && rlast) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: the 2-entry buffer is reset because rdata is required to read 0 out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_q      <= '0;
            pop_left  <= '0;
            send_left <= '0;
            inflight  <= 1'b0;
            head      <= 1'b0;
            occ       <= 2'd0;
            for (int i = 0; i < 2; i++) buf_mem[i] <= '0;
        end else begin
            if (cmd_take) begin
                id_q      <= cmd_id;
                pop_left  <= {1'b0, cmd_len} + CNT_ONE;
                send_left <= {1'b0, cmd_len} + CNT_ONE;
            end else begin
                if (fifo_rd_en) pop_left  <= pop_left - CNT_ONE;
                if (send)       send_left <= send_left - CNT_ONE;
            end
            inflight <= fifo_rd_en;
            if (inflight) buf_mem[wr_idx] <= fifo_data;
            if (send)     head <= ~head;
            occ <= occ_after_send + {1'b0, inflight};
        end
    end

endmodule

// File: tb/tb_axi_rdata_fifo_drain.sv
// Directed bench for axi_rdata_fifo_drain: a queue-based FIFO model feeds the DUT and a
// scoreboard of expected beats is checked at every R-channel handshake.
module tb_axi_rdata_fifo_drain;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  id;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_id;
    logic [7:0]  cmd_len;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [31:0] fifo_data = '0;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic        rlast;
    logic        busy;

    axi_rdata_fifo_drain #(.DATA_SIZE(32), .ID_W(4), .LEN_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_id     (cmd_id),
        .cmd_len    (cmd_len),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .rid        (rid),
        .rresp      (rresp),
        .rlast      (rlast),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          beats_seen = 0;
    int          hs_cyc [$];
    beat_t       exp_q [$];
    logic [31:0] fifo_q [$];
    logic [31:0] push_q [$];
    logic        pop_req = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_id;
    logic        prev_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: pop decided from rd_en sampled mid-cycle, data valid the cycle after.
    always @(negedge clk) pop_req = fifo_rd_en && reset_n;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_q.delete();
            push_q.delete();
            fifo_empty <= 1'b1;
        end else begin
            if (pop_req && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
            while (push_q.size() != 0) fifo_q.push_back(push_q.pop_front());
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // R-channel monitor and scoreboard
    always @(negedge clk) begin
        beat_t e;
        if (!reset_n) begin
            hold_prev = 1'b0;
        end else begin
            if (fifo_rd_en) check("rd_en_while_empty", fifo_empty, 0);
            if (hold_prev) begin
                check("rvalid_hold", rvalid, 1);
                check("rdata_hold", rdata, prev_data);
                check("rid_hold", rid, prev_id);
                check("rlast_hold", rlast, prev_last);
            end
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", rdata, e.d);
                    check("rid", rid, e.id);
                    check("rlast", rlast, e.last);
                    check("rresp", rresp, 0);
                end
                hs_cyc.push_back(cyc);
                beats_seen++;
            end
            hold_prev = rvalid && !rready;
            prev_data = rdata;
            prev_id   = rid;
            prev_last = rlast;
        end
    end

    task automatic load_exp(input logic [3:0] id, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) exp_q.push_back('{d: base + i, id: id, last: (i == n - 1)});
    endtask

    task automatic push_words(input logic [31:0] base, input int start, input int count);
        for (int i = start; i < start + count; i++) push_q.push_back(base + i);
    endtask

    task automatic send_cmd(input logic [3:0] id, input logic [7:0] len, output int acc);
        @(posedge clk); #1;
        cmd_id = id; cmd_len = len; cmd_valid = 1'b1;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge clk); #1;
            k++;
        end
        check("drain_done", exp_q.size(), 0);
    endtask

    task automatic wait_beats(input int base, input int n, input int limit);
        int k = 0;
        while (beats_seen - base < n && k < limit) begin
            @(negedge clk); #1;
            k++;
        end
        check("wait_beats", (beats_seen - base) >= n, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int base;

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_id = '0; cmd_len = '0; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rid", rid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_busy", busy, 0);
        @(negedge clk); reset_n = 1'b1;

        // 4-beat burst, FIFO preloaded, back-to-back beats after 2-cycle latency
        load_exp(4'd3, 4, 32'hA0);
        push_words(32'hA0, 0, 4);
        repeat (2) @(posedge clk);
        base = beats_seen;
        send_cmd(4'd3, 8'd3, acc);
        drain(50);
        check("b1_count", beats_seen - base, 4);
        check("b1_latency", hs_cyc[base] - acc, 2);
        check("b1_consecutive", hs_cyc[base + 3] - hs_cyc[base], 3);

        // single-beat burst; cmd_ready returns the cycle after the handshake
        load_exp(4'd5, 1, 32'h55);
        push_words(32'h55, 0, 1);
        repeat (2) @(posedge clk);
        base = beats_seen;
        send_cmd(4'd5, 8'd0, acc);
        drain(50);
        check("b2_count", beats_seen - base, 1);
        check("b2_busy_at_hs", cmd_ready, 0);
        @(negedge clk); #1;
        check("b2_cmd_ready_back", cmd_ready, 1);
        check("b2_busy_clear", busy, 0);

        // rready stalled 10 cycles mid-burst; a command offered meanwhile is ignored
        load_exp(4'd9, 8, 32'hB0);
        push_words(32'hB0, 0, 8);
        repeat (2) @(posedge clk);
        base = beats_seen;
        send_cmd(4'd9, 8'd7, acc);
        wait_beats(base, 2, 50);
        @(posedge clk); #1;
        rready = 1'b0;
        cmd_id = 4'hF; cmd_len = 8'd0; cmd_valid = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("stall_cmd_ready", cmd_ready, 0);
        check("stall_rd_en", fifo_rd_en, 0);
        check("stall_rvalid", rvalid, 1);
        check("stall_head", rdata, exp_q[0].d);
        check("stall_fifo_left", fifo_q.size(), 8 - (beats_seen - base) - 2);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rready = 1'b1;
        drain(50);
        check("b3_count", beats_seen - base, 8);

        // FIFO runs dry after two beats for several cycles
        load_exp(4'd6, 8, 32'hC0);
        push_words(32'hC0, 0, 2);
        repeat (2) @(posedge clk);
        base = beats_seen;
        send_cmd(4'd6, 8'd7, acc);
        wait_beats(base, 2, 50);
        repeat (5) @(negedge clk);
        #1;
        check("dry_rvalid", rvalid, 0);
        check("dry_rd_en", fifo_rd_en, 0);
        check("dry_busy", busy, 1);
        push_words(32'hC0, 2, 6);
        drain(50);
        check("b4_count", beats_seen - base, 8);

        // maximum length burst
        load_exp(4'hA, 256, 32'h1000);
        push_words(32'h1000, 0, 256);
        repeat (2) @(posedge clk);
        base = beats_seen;
        send_cmd(4'hA, 8'd255, acc);
        drain(600);
        check("b5_count", beats_seen - base, 256);
        check("b5_consecutive", hs_cyc[base + 255] - hs_cyc[base], 255);
        @(negedge clk); #1;
        check("b5_busy_clear", busy, 0);

        // asynchronous reset in the middle of a burst
        load_exp(4'd4, 8, 32'hD0);
        push_words(32'hD0, 0, 8);
        repeat (2) @(posedge clk);
        base = beats_seen;
        send_cmd(4'd4, 8'd7, acc);
        wait_beats(base, 3, 50);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("arst_rvalid", rvalid, 0);
        check("arst_rd_en", fifo_rd_en, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        #1;
        check("arst_rdata", rdata, 0);
        check("arst_rid", rid, 0);

        load_exp(4'd2, 2, 32'hE0);
        push_words(32'hE0, 0, 2);
        repeat (2) @(posedge clk);
        base = beats_seen;
        send_cmd(4'd2, 8'd1, acc);
        drain(50);
        check("b6_count", beats_seen - base, 2);
        check("b6_latency", hs_cyc[base] - acc, 2);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
